cam_stream_gen: RTL

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

---
 rtl/cam_stream_gen.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cam_stream_gen.sv
// -----------------------------------------------------------------------------
// cam_stream_gen
//   Synthetic OV-style camera source. It produces an RGB565 byte stream with
//   VSYNC/HREF framing, driven by a pixel clock that is CLOCK/2. Four built-in
//   test patterns are available: colour bars, solid red, a 16x16 checker, and
//   red/blue ramps.
//
//   Ports
//     CLOCK      in   system clock; every flop uses its rising edge
//     RESET      in   asynchronous reset, active low
//     EN         in   frame generation enable (sampled on PCLK falling edges)
//     PATTERN    in   [1:0] pattern select, latched when a frame starts
//     PCLK       out  pixel clock, CLOCK/2, held low during reset
//     VSYNC      out  frame sync, active high
//     HREF       out  line valid, active high
//     DATA       out  [7:0] pixel byte; two bytes per RGB565 pixel, 0 while HREF=0
//     FRAME_DONE out  one-CLOCK pulse when a frame finishes
//     FRAME_CNT  out  [7:0] completed-frame counter, wraps 255->0
//
//   Build option
//     CAM_GEN_SCROLL_EN : if defined, the pattern x coordinate becomes
//                         (x + FRAME_CNT) mod H_ACTIVE, so the image scrolls
//                         one pixel per frame. If undefined, patterns are static.
//
//   Every timing parameter is expected to be >= 1, and H_ACTIVE >= 2.
// -----------------------------------------------------------------------------
module cam_stream_gen #(
  parameter int H_ACTIVE = 176,
  parameter int V_ACTIVE = 144,
  parameter int H_BLANK  = 16,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 2,
  parameter int V_FRONT  = 2
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       EN,
  input  logic [1:0] PATTERN,
  output logic       PCLK,
  output logic       VSYNC,
  output logic       HREF,
  output logic [7:0] DATA,
  output logic       FRAME_DONE,
  output logic [7:0] FRAME_CNT
);

  // Line time, measured in PCLK periods.
  localparam int L    = 2*H_ACTIVE + H_BLANK;
  localparam int HW   = $clog2(L);
  localparam int M1   = (VS_LINES > V_BACK)  ? VS_LINES : V_BACK;
  localparam int M2   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int VMAX = (M1 > M2) ? M1 : M2;
  localparam int VW   = $clog2(VMAX + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(L - 1);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(2*H_ACTIVE - 1);
  localparam logic [VW-1:0] VS_LAST    = VW'(VS_LINES - 1);
  localparam logic [VW-1:0] VB_LAST    = VW'(V_BACK - 1);
  localparam logic [VW-1:0] VA_LAST    = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VF_LAST    = VW'(V_FRONT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VS     = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_VFRONT = 3'd5;

  logic          pclk_q;
  logic [2:0]    state, nxt_state;
  logic [HW-1:0] h, nxt_h;      // PCLK index within the current line (0..L-1)
  logic [VW-1:0] v, nxt_v;      // line index within the current state
  logic [1:0]    pat_q, nxt_pat;
  logic          line_end;
  logic          frame_end;
  logic          vsync_q, href_q, fd_q;
  logic [7:0]    data_q, fcnt_q;
  logic [7:0]    pix_byte;
  logic [15:0]   x_s;
  logic [31:0]   x8;
  logic [2:0]    bar;
  logic [15:0]   rgb;

  // The framing state advances only on edges where PCLK goes from 1 to 0.
  // The receiver samples on the PCLK rising edge, half a period later, so
  // all outputs are stable by then.
  logic fall;
  assign fall     = pclk_q;
  assign line_end = (h == H_LAST);

  // ---------------------------------------------------------------------------
  // Frame sequencer. The line counter h runs 0..L-1 in every state except
  // IDLE. ACTIVE covers h < 2*H_ACTIVE and HBLANK covers the remainder of the
  // line, so horizontal timing is the same everywhere.
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt_state = state;
    nxt_h     = h;
    nxt_v     = v;
    nxt_pat   = pat_q;
    frame_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (EN) begin
          nxt_state = S_VS;
          nxt_h     = '0;
          nxt_v     = '0;
          nxt_pat   = PATTERN;
        end
      end
      S_VS: begin
        if (line_end) begin
          nxt_h = '0;
          if (v == VS_LAST) begin
            nxt_state = S_VBACK;
            nxt_v     = '0;
          end else begin
            nxt_v = v + 1'b1;
          end
        end else begin
          nxt_h = h + 1'b1;
        end
      end
      S_VBACK: begin
        if (line_end) begin
          nxt_h = '0;
          if (v == VB_LAST) begin
            nxt_state = S_ACTIVE;
            nxt_v     = '0;
          end else begin
            nxt_v = v + 1'b1;
          end
        end else begin
          nxt_h = h + 1'b1;
        end
      end
      S_ACTIVE: begin
        nxt_h = h + 1'b1;
        if (h == H_ACT_LAST) nxt_state = S_HBLANK;
      end
      S_HBLANK: begin
        if (line_end) begin
          nxt_h = '0;
          if (v == VA_LAST) begin
            nxt_state = S_VFRONT;
            nxt_v     = '0;
          end else begin
            nxt_state = S_ACTIVE;
            nxt_v     = v + 1'b1;
          end
        end else begin
          nxt_h = h + 1'b1;
        end
      end
      S_VFRONT: begin
        if (line_end) begin
          nxt_h = '0;
          if (v == VF_LAST) begin
            // Back-to-back frames go straight into VS with no idle PCLK.
            // EN is checked only here, so dropping it mid-frame never cuts a
            // frame short.
            frame_end = 1'b1;
            nxt_v     = '0;
            if (EN) begin
              nxt_state = S_VS;
              nxt_pat   = PATTERN;
            end else begin
              nxt_state = S_IDLE;
            end
          end else begin
            nxt_v = v + 1'b1;
          end
        end else begin
          nxt_h = h + 1'b1;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_h     = '0;
        nxt_v     = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel generation. This looks at the *next* counters, so the registered
  // DATA byte lines up with the registered HREF. pat_q is already latched when
  // VS is entered, well before the first active byte.
  // ---------------------------------------------------------------------------
`ifdef CAM_GEN_SCROLL_EN
  localparam int XOW = $clog2(H_ACTIVE);
  logic [XOW-1:0] scroll_off;   // FRAME_CNT mod H_ACTIVE, tracked incrementally
  logic [15:0]    x_sum;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      scroll_off <= '0;
    end else if (fall && frame_end) begin
      // Because 256 is not a multiple of H_ACTIVE, the offset must restart
      // at zero whenever the 8-bit frame counter wraps.
      if (fcnt_q == 8'hFF || scroll_off == XOW'(H_ACTIVE - 1)) scroll_off <= '0;
      else                                                       scroll_off <= scroll_off + 1'b1;
    end
  end

  always_comb begin
    x_sum = 16'(nxt_h[HW-1:1]) + 16'(scroll_off);
    x_s   = (x_sum >= 16'(H_ACTIVE)) ? x_sum - 16'(H_ACTIVE) : x_sum;
  end
`else
  always_comb x_s = 16'(nxt_h[HW-1:1]);
`endif

  always_comb begin
    // bar = (x*8)/H_ACTIVE, computed with compares against constant
    // thresholds so that no divider is needed.
    x8  = {13'd0, x_s, 3'b000};
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x8 >= 32'(k*H_ACTIVE)) bar = 3'(k);
    end

    case (pat_q)
      2'd0: begin
        case (bar)
          3'd0:    rgb = 16'hFFFF;
          3'd1:    rgb = 16'hFFE0;
          3'd2:    rgb = 16'h07FF;
          3'd3:    rgb = 16'h07E0;
          3'd4:    rgb = 16'hF81F;
          3'd5:    rgb = 16'hF800;
          3'd6:    rgb = 16'h001F;
          default: rgb = 16'h0000;
        endcase
      end
      2'd1:    rgb = 16'hF800;
      2'd2:    rgb = (x_s[4] ^ (|(16'(nxt_v) & 16'h0010))) ? 16'hFFFF : 16'h0000;
      default: rgb = {x_s[7:3], 6'b000000, ~x_s[7:3]};
    endcase

    // An even PCLK index in the line carries the high byte.
    pix_byte = nxt_h[0] ? rgb[7:0] : rgb[15:8];
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pclk_q  <= 1'b0;
      state   <= S_IDLE;
      h       <= '0;
      v       <= '0;
      pat_q   <= 2'd0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      fd_q    <= 1'b0;
      fcnt_q  <= 8'h00;
    end else begin
      pclk_q <= ~pclk_q;
      fd_q   <= 1'b0;   // a set on a falling edge lasts exactly one CLOCK
      if (fall) begin
        state   <= nxt_state;
        h       <= nxt_h;
        v       <= nxt_v;
        pat_q   <= nxt_pat;
        vsync_q <= (nxt_state == S_VS);
        href_q  <= (nxt_state == S_ACTIVE);
        data_q  <= (nxt_state == S_ACTIVE) ? pix_byte : 8'h00;
        if (frame_end) begin
          fd_q   <= 1'b1;
          fcnt_q <= fcnt_q + 8'd1;
        end
      end
    end
  end

  assign PCLK       = pclk_q;
  assign VSYNC      = vsync_q;
  assign HREF       = href_q;
  assign DATA       = data_q;
  assign FRAME_DONE = fd_q;
  assign FRAME_CNT  = fcnt_q;

endmodule
